// File: rtl/hex_display_if.sv
// Register-bus bundle between the I/O expansion bus and the hex display controller.
// The bus master drives the write strobes and data; the controller returns readback.
interface hex_display_if;
  logic [15:0] data_in;
  logic        value_load;
  logic        ctrl_load;
  logic [15:0] value_out;
  logic [15:0] ctrl_out;

  modport master (
    output data_in,
    output value_load,
    output ctrl_load,
    input  value_out,
    input  ctrl_out
  );

  modport slave (
    input  data_in,
    input  value_load,
    input  ctrl_load,
    output value_out,
    output ctrl_out
  );
endinterface

// File: rtl/hex_display_ctrl.sv
// Four-digit seven-segment display controller: value/control registers, glyph decode,
// leading-zero suppression, blink timer and PWM brightness with registered outputs.
module hex_display_ctrl #(
  parameter int BLINK_HALF_MS = 250
) (
  input  logic             sysclk,
  input  logic             sysreset,
  hex_display_if.slave     bus,
  input  logic             pulse1k,
  output logic [6:0]       hex0,
  output logic [6:0]       hex1,
  output logic [6:0]       hex2,
  output logic [6:0]       hex3,
  output logic [3:0]       hex_dp
);

  localparam logic [9:0]  BLINK_LAST = 10'(BLINK_HALF_MS - 1);
  localparam logic [13:0] CTRL_RST   = 14'h3CF0;
  localparam logic [6:0]  SEG_OFF    = 7'h7F;

  // Active-low glyphs, bit0 = segment a .. bit6 = segment g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [15:0] value_p0;
  logic [13:0] ctrl_p0;
  logic [9:0]  blink_cnt_p0;
  logic        blink_phase_p0;
  logic [3:0]  pwm_cnt_p0;

  logic [3:0]  dp_en;
  logic [3:0]  digit_en;
  logic        lz_suppress;
  logic        blink_en;
  logic [3:0]  brightness;

  assign dp_en       = ctrl_p0[3:0];
  assign digit_en    = ctrl_p0[7:4];
  assign lz_suppress = ctrl_p0[8];
  assign blink_en    = ctrl_p0[9];
  assign brightness  = ctrl_p0[13:10];

  assign bus.value_out = value_p0;
  assign bus.ctrl_out  = {2'b00, ctrl_p0};

  // ---- stage p0: architectural registers and timers ----
  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      value_p0 <= 16'h0000;
      ctrl_p0  <= CTRL_RST;
    end else begin
      if (bus.value_load) value_p0 <= bus.data_in;
      if (bus.ctrl_load)  ctrl_p0  <= bus.data_in[13:0];
    end
  end

  // A control write that clears blink_en must beat a coincident pulse1k.
  always_ff @(posedge sysclk) begin
    if (sysreset || !blink_en || (bus.ctrl_load && !bus.data_in[9])) begin
      blink_cnt_p0   <= 10'd0;
      blink_phase_p0 <= 1'b0;
    end else if (pulse1k) begin
      if (blink_cnt_p0 == BLINK_LAST) begin
        blink_cnt_p0   <= 10'd0;
        blink_phase_p0 <= ~blink_phase_p0;
      end else begin
        blink_cnt_p0 <= blink_cnt_p0 + 10'd1;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (sysreset) pwm_cnt_p0 <= 4'd0;
    else          pwm_cnt_p0 <= pwm_cnt_p0 + 4'd1;
  end

  logic       gate;
  logic [3:0] zero_blank;
  logic [6:0] seg_nxt [4];
  logic [3:0] dp_nxt;

  always_comb begin
    gate = ((brightness == 4'hF) || (pwm_cnt_p0 < brightness)) &&
           !(blink_en && blink_phase_p0);

    // Suppression cascades down from the top digit; digit 0 always shows.
    zero_blank[3] = lz_suppress && (value_p0[15:12] == 4'h0);
    zero_blank[2] = zero_blank[3] && (value_p0[11:8] == 4'h0);
    zero_blank[1] = zero_blank[2] && (value_p0[7:4] == 4'h0);
    zero_blank[0] = 1'b0;

    for (int n = 0; n < 4; n++) begin
      seg_nxt[n] = SEG_OFF;
      if (gate && digit_en[n] && !zero_blank[n])
        seg_nxt[n] = hex_to_seg(value_p0[4*n +: 4]);
    end

    dp_nxt = ~(dp_en & {4{gate}});
  end

  // ---- stage p1: registered display outputs ----
  logic [6:0] seg_p1 [4];
  logic [3:0] dp_p1;

  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      for (int n = 0; n < 4; n++) seg_p1[n] <= SEG_OFF;
      dp_p1 <= 4'hF;
    end else begin
      for (int n = 0; n < 4; n++) seg_p1[n] <= seg_nxt[n];
      dp_p1 <= dp_nxt;
    end
  end

  assign hex0   = seg_p1[0];
  assign hex1   = seg_p1[1];
  assign hex2   = seg_p1[2];
  assign hex3   = seg_p1[3];
  assign hex_dp = dp_p1;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed scoreboard bench for hex_display_ctrl with a short blink half-period.
module tb_hex_display_ctrl;

  logic       sysclk = 1'b0;
  logic       sysreset;
  logic       pulse1k;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic [3:0] hex_dp;

  hex_display_if bus ();

  hex_display_ctrl #(.BLINK_HALF_MS(3)) dut (
    .sysclk   (sysclk),
    .sysreset (sysreset),
    .bus      (bus.slave),
    .pulse1k  (pulse1k),
    .hex0     (hex0),
    .hex1     (hex1),
    .hex2     (hex2),
    .hex3     (hex3),
    .hex_dp   (hex_dp)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  localparam logic [31:0] DARK  = 32'hFFFF_FFFF;
  localparam logic [31:0] ZERO4 = {7'h40, 7'h40, 7'h40, 7'h40, 4'hF};

  function automatic logic [31:0] disp(input logic [6:0] h3, h2, h1, h0,
                                       input logic [3:0] dp);
    return {h3, h2, h1, h0, dp};
  endfunction

  function automatic logic [31:0] disp_now();
    return {hex3, hex2, hex1, hex0, hex_dp};
  endfunction

  task automatic expect_val(input string tag, input logic [31:0] exp);
    sb_q.push_back('{tag, exp});
  endtask

  task automatic compare(input logic [31:0] obs);
    sb_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $error("FAIL sb_empty observed=%h required=queued_entry", obs);
      return;
    end
    e = sb_q.pop_front();
    assert (obs === e.exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h required=%h", e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic load(input logic v, input logic c, input logic [15:0] d);
    bus.value_load = v;
    bus.ctrl_load  = c;
    bus.data_in    = d;
    tick();
    bus.value_load = 1'b0;
    bus.ctrl_load  = 1'b0;
  endtask

  // Three idle cycles, a pulse1k cycle, then one cycle for the output register.
  task automatic pulse_period();
    repeat (3) tick();
    pulse1k = 1'b1;
    tick();
    pulse1k = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lit;
    sysreset       = 1'b1;
    pulse1k        = 1'b0;
    bus.data_in    = 16'h0000;
    bus.value_load = 1'b0;
    bus.ctrl_load  = 1'b0;

    // Reset wins over coincident loads and pulse1k.
    tick();
    pulse1k = 1'b1;
    expect_val("rst_disp", DARK);
    expect_val("rst_value", 32'h0000);
    expect_val("rst_ctrl", 32'h3CF0);
    load(1'b1, 1'b1, 16'hFFFF);
    pulse1k = 1'b0;
    compare(disp_now());
    compare({16'h0, bus.value_out});
    compare({16'h0, bus.ctrl_out});

    sysreset = 1'b0;
    expect_val("release_0000", ZERO4);
    tick();
    compare(disp_now());

    // Plain value write with one-cycle output latency.
    expect_val("wr_value_out", 32'h12AF);
    expect_val("latency_old", ZERO4);
    expect_val("glyph_12AF", disp(7'h79, 7'h24, 7'h08, 7'h0E, 4'hF));
    load(1'b1, 1'b0, 16'h12AF);
    compare({16'h0, bus.value_out});
    compare(disp_now());
    tick();
    compare(disp_now());

    // Reserved bits drop; digits disabled but dp stays independent of blanking.
    expect_val("ctrl_reserved", 32'h3D05);
    load(1'b0, 1'b1, 16'hFD05);
    compare({16'h0, bus.ctrl_out});
    load(1'b1, 1'b0, 16'h0000);
    tick();
    for (int i = 0; i < 4; i++) begin
      expect_val("dp_only", disp(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b1010));
      compare(disp_now());
      tick();
    end

    // Leading-zero suppression.
    load(1'b0, 1'b1, 16'h3DF0);
    expect_val("lz_0040", disp(7'h7F, 7'h7F, 7'h19, 7'h40, 4'hF));
    load(1'b1, 1'b0, 16'h0040);
    tick();
    compare(disp_now());
    expect_val("lz_0000", disp(7'h7F, 7'h7F, 7'h7F, 7'h40, 4'hF));
    load(1'b1, 1'b0, 16'h0000);
    tick();
    compare(disp_now());

    // Brightness 4: a quarter duty over two full PWM periods.
    load(1'b0, 1'b1, 16'h10F0);
    tick();
    expect_val("pwm_b4_lit", 32'd8);
    lit = 0;
    for (int i = 0; i < 32; i++) begin
      if (hex0 != 7'h7F) lit++;
      tick();
    end
    compare(32'(lit));

    expect_val("pwm_b0_lit", 32'd0);
    load(1'b0, 1'b1, 16'h00FF);
    tick();
    lit = 0;
    for (int i = 0; i < 32; i++) begin
      if (disp_now() != DARK) lit++;
      tick();
    end
    compare(32'(lit));

    // Blink with a three-pulse half-period.
    load(1'b0, 1'b1, 16'h3EF0);
    tick();
    for (int p = 1; p <= 10; p++) begin
      expect_val($sformatf("blink_p%0d", p), (((p / 3) % 2) == 1) ? DARK : ZERO4);
      pulse_period();
      compare(disp_now());
    end

    // Clearing blink_en on a pulse cycle while blanked.
    repeat (3) tick();
    pulse1k = 1'b1;
    expect_val("blink_clear", ZERO4);
    load(1'b0, 1'b1, 16'h3CF0);
    pulse1k = 1'b0;
    tick();
    compare(disp_now());

    // Re-enable: the counter must have restarted from zero.
    load(1'b0, 1'b1, 16'h3EF0);
    expect_val("reblink_p1", ZERO4);
    expect_val("reblink_p2", ZERO4);
    expect_val("reblink_p3", DARK);
    for (int p = 1; p <= 3; p++) begin
      pulse_period();
      compare(disp_now());
    end

    // Reset while blanked by blink with a full value loaded.
    expect_val("blanked_ffff", DARK);
    load(1'b1, 1'b0, 16'hFFFF);
    tick();
    compare(disp_now());
    sysreset = 1'b1;
    expect_val("mid_rst_disp", DARK);
    tick();
    compare(disp_now());
    sysreset = 1'b0;
    expect_val("post_rst_disp", ZERO4);
    expect_val("post_rst_value", 32'h0000);
    expect_val("post_rst_ctrl", 32'h3CF0);
    tick();
    compare(disp_now());
    compare({16'h0, bus.value_out});
    compare({16'h0, bus.ctrl_out});

    // Blink state must restart from zero after reset.
    load(1'b0, 1'b1, 16'h3EF0);
    expect_val("post_rst_blink", ZERO4);
    pulse_period();
    pulse_period();
    compare(disp_now());

    // Simultaneous value and control write.
    expect_val("both_value", 32'h7CF3);
    expect_val("both_ctrl", 32'h3CF3);
    expect_val("both_disp", disp(7'h78, 7'h46, 7'h0E, 7'h30, 4'hC));
    load(1'b1, 1'b1, 16'h7CF3);
    compare({16'h0, bus.value_out});
    compare({16'h0, bus.ctrl_out});
    tick();
    compare(disp_now());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hex_display_ctrl.md
HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Interface
REQ-001 SHALL have parameter BLINK_HALF_MS, default 250: number of pulse1k strobes per blink half-period, legal range 1..1023.
REQ-002 SHALL have port sysclk  input  1  the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port sysreset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port data_in  input  16  register write data from the I/O expansion bus.
REQ-005 SHALL have port value_load  input  1  one-cycle strobe that writes data_in into the value register.
REQ-006 SHALL have port ctrl_load  input  1  one-cycle strobe that writes data_in into the control register.
REQ-007 SHALL have port value_out  output  16  current value register, for bus readback.
REQ-008 SHALL have port ctrl_out  output  16  current control register, for bus readback; bits [15:14] always read 0.
REQ-009 SHALL have port pulse1k  input  1  one-sysclk strobe at 1 kHz from the realtime divider chain.
REQ-010 SHALL have ports hex0, hex1, hex2, hex3  output  7 each  segments, active low; bit0 = segment a through bit6 = segment g; hex0 is the low-order digit.
REQ-011 SHALL have port hex_dp  output  4  decimal points, active low; bit0 is the right-most digit.

Function
REQ-012 Value register SHALL hold four 4-bit digits: digit n = value[4n+3:4n].
REQ-013 Control register fields SHALL be: [3:0] dp_en (active high); [7:4] digit_en (active high); [8] lz_suppress; [9] blink_en; [13:10] brightness; [15:14] reserved, written as don't-care and stored as 0.
REQ-014 If value_load and ctrl_load are both asserted in one cycle, both registers SHALL load data_in.
REQ-015 Each digit SHALL decode hex 0-F to standard seven-segment glyphs, with lowercase b and d and uppercase A, C, E and F.
REQ-016 Digit n SHALL be blank (all segments off) when digit_en[n]=0.
REQ-017 With lz_suppress=1, digits 3, 2 and 1 SHALL each be blank when that digit and every higher digit equal 0.
REQ-018 Digit 0 SHALL never be zero-suppressed.
REQ-019 Zero suppression SHALL consider the value only, irrespective of digit_en.
REQ-020 The dp for digit n SHALL be lit iff dp_en[n]=1 and the global gate (REQ-024) is open; it SHALL be independent of digit blanking.
REQ-021 Blink: a 10-bit counter SHALL advance on each pulse1k while blink_en=1.
REQ-022 When the count reaches BLINK_HALF_MS-1 and pulse1k is high, the counter SHALL return to 0 and blink_phase SHALL toggle.
REQ-023 While blink_en=0, the blink counter and blink_phase SHALL be held at 0; a ctrl_load clearing blink_en SHALL win over a coincident pulse1k.
REQ-024 PWM: a 4-bit counter SHALL free-run on sysclk, wrapping 15->0; the global gate SHALL be open iff (brightness==15 or pwm_cnt < brightness) and not (blink_en and blink_phase).
REQ-025 brightness=0 SHALL keep every segment and dp off.
REQ-026 brightness=15 SHALL give 100% duty.
REQ-027 When the gate is closed, all hex outputs and hex_dp SHALL be driven all ones.
REQ-028 hex0-hex3 and hex_dp SHALL be registered: a register write at edge k SHALL be visible on the outputs after edge k+1 (1-cycle latency).
REQ-029 value_out and ctrl_out SHALL reflect a write immediately after the loading edge.
REQ-030 Display state SHALL not depend on the PWM phase at the time of a register write.

Reset
REQ-031 On sysreset: value=16'h0000; ctrl=16'h3CF0 (all digits enabled, brightness 15, dp, lz_suppress and blink off).
REQ-032 On sysreset: blink counter and blink_phase = 0; pwm_cnt = 0.
REQ-033 On sysreset: hex0-hex3=7'h7F and hex_dp=4'hF, taking effect the edge after reset is sampled.
REQ-034 From the first edge after release, the outputs SHALL display "0000".
REQ-035 sysreset SHALL take priority over value_load, ctrl_load and pulse1k in the same cycle.
REQ-036 Reset asserted mid-blink or mid-PWM SHALL return all state to the values in REQ-031 and REQ-032.

Verification
REQ-037 Reset, release, then write value 16'h12AF -> hex3=7'h79 ("1"), hex2=7'h24 ("2"), hex1=7'h08 ("A"), hex0=7'h0E ("F") one cycle after the load edge; hex_dp=4'hF.
REQ-038 ctrl=16'h3D05 (lz_suppress, dp_en=0101, digit_en=0) then value=16'h0000 -> all digits blank; hex_dp=4'b1010 constantly.
REQ-039 ctrl=16'h3DF0 and value=16'h0040 -> hex3 and hex2 blank, hex1="4" (7'h19), hex0="0" (7'h40); then value=16'h0000 -> only hex0 lit, showing "0".
REQ-040 ctrl brightness=4 (16'h10F0) -> over 32 consecutive cycles, exactly 8 cycles show segments lit; brightness=0 -> 0 cycles lit.
REQ-041 BLINK_HALF_MS=3 and ctrl=16'h3EF0 with pulse1k every 5 cycles -> display toggles off/on every 3rd pulse1k; clearing blink_en on a pulse1k cycle -> display on the next cycle and counter=0.
REQ-042 Assert sysreset while blanked by blink with value=16'hFFFF -> outputs all ones, then "0000" after release, and value_out=0, ctrl_out=16'h3CF0.
